// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle instruction controller.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package ctrl_pkg;

    // Opcodes recognised by the controller
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // alu_op encodings
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_RTYPE = 2'b01;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Opcodes that execute; anything else halts the machine.
    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_ITYPE) ||
               (op == OP_LOAD)  || (op == OP_STORE);
    endfunction

    // Opcodes that need a data-memory access after EXEC.
    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running 32-bit count of retired instructions, wraps to zero.
// Latency: count reflects an inc pulse on the cycle after it is sampled.
// Backpressure: none; inc is taken every cycle it is high.
// Ports: clk, rst (sync, active high), inc (one-cycle retire pulse),
//        count (current total).
module retire_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc) begin
            // Natural 32-bit overflow gives the required wrap to 0
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with HALT on bad opcode.
// Latency: 4 cycles (R/I/store), 5 cycles (load), +1 per cycle mem_ready is low.
// Backpressure: memory stalls FETCH and MEM by holding mem_ready low.
// Ports: clk, rst (sync, active high), opcode, mem_ready in; memory handshake
//        (mem_req/mem_we/iord), datapath enables/selects, alu_op,
//        instr_retired, retire_count and halted out.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        mdr_write,
    output logic        aluout_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        instr_retired,
    output logic [31:0] retire_count,
    output logic        halted
);

    state_t      state_q, state_d;
    logic [6:0]  opcode_q, opcode_d;
    logic [31:0] count_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        mdr_write     = 1'b0;
        aluout_write  = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        alu_op        = ALU_ADD;
        instr_retired = 1'b0;
        halted        = 1'b0;

        // Reset gates every output so no memory write or retire can leak
        // out during a reset cycle, whatever the state register holds.
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // Later states use only the latched copy of the opcode
                    opcode_d = opcode;
                    state_d  = is_legal_op(opcode) ? ST_EXEC : ST_HALT;
                end
                ST_EXEC: begin
                    aluout_write = 1'b1;
                    if (opcode_q == OP_RTYPE) begin
                        alu_src = 1'b0;
                        alu_op  = ALU_RTYPE;
                    end else begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADD;
                    end
                    state_d = is_mem_op(opcode_q) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (opcode_q == OP_STORE);
                    if (mem_ready) begin
                        if (opcode_q == OP_STORE) begin
                            // Store has no writeback; it retires here
                            instr_retired = 1'b1;
                            state_d       = ST_FETCH;
                        end else begin
                            mdr_write = 1'b1;
                            state_d   = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    reg_write     = 1'b1;
                    mem_to_reg    = (opcode_q == OP_LOAD);
                    instr_retired = 1'b1;
                    state_d       = ST_FETCH;
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    retire_counter u_retire (
        .clk   (clk),
        .rst   (rst),
        .inc   (instr_retired),
        .count (count_w)
    );

    assign retire_count = rst ? 32'd0 : count_w;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction cycle-list model plus literal pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicycle_ctrl;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011;
    localparam logic [6:0] BAD   = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_write, pc_write, mdr_write;
    logic        aluout_write, reg_write, mem_to_reg, alu_src;
    logic [1:0]  alu_op;
    logic        instr_retired, halted;
    logic [31:0] retire_count;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .mdr_write     (mdr_write),
        .aluout_write  (aluout_write),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .instr_retired (instr_retired),
        .retire_count  (retire_count),
        .halted        (halted)
    );

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_write, pc_write, mdr_write;
        logic       aluout_write, reg_write, mem_to_reg, alu_src;
        logic [1:0] alu_op;
        logic       instr_retired, halted;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        mr;
        outs_t       exp;
        logic [31:0] cnt;
    } step_t;

    step_t       q[$];
    logic [31:0] m_cnt;
    int          total = 0;
    int          bad = 0;

    // Observations of the DUT over one run()
    int          obs_cycles, obs_ret_at, obs_rets, obs_mdr, obs_regw, obs_halt;
    logic [31:0] obs_first_cnt;

    task automatic chk(input string name, input int step,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, step, act, exp);
        end
    endtask

    // Append one expected cycle; the model counter advances after a retire.
    task automatic push(input logic r, input logic [6:0] op, input logic mr,
                        input outs_t e);
        step_t s;
        s.rst = r;
        s.op  = op;
        s.mr  = mr;
        s.exp = r ? outs_t'(0) : e;
        s.cnt = r ? 32'd0 : m_cnt;
        q.push_back(s);
        if (r) m_cnt = 32'd0;
        else if (e.instr_retired) m_cnt = m_cnt + 32'd1;
    endtask

    task automatic model_reset(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 7'd0, 1'b0, outs_t'(0));
    endtask

    task automatic model_halt(input int n);
        outs_t e;
        e = '0;
        e.halted = 1'b1;
        // mem_ready held high to show HALT ignores it
        for (int i = 0; i < n; i++) push(1'b0, BAD, 1'b1, e);
    endtask

    // Expand one instruction into its expected cycles. After DECODE a junk
    // opcode is driven, since later behaviour must use the latched value.
    task automatic model_instr(input logic [6:0] op, input int fw, input int mw,
                               input bit abort_mem);
        outs_t e;
        logic  is_ld, is_st, legal;
        is_ld = (op == LD_OP);
        is_st = (op == ST_OP);
        legal = (op == R_OP) || (op == I_OP) || is_ld || is_st;
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_req = 1'b1;
            push(1'b0, op, 1'b0, e);
        end
        e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(1'b0, op, 1'b1, e);
        e = '0;
        push(1'b0, op, 1'b1, e);
        if (!legal) return;
        e = '0; e.aluout_write = 1'b1;
        e.alu_src = (op != R_OP);
        e.alu_op  = (op == R_OP) ? 2'b01 : 2'b00;
        push(1'b0, BAD, 1'b1, e);
        if (is_ld || is_st) begin
            for (int i = 0; i <= mw; i++) begin
                e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = is_st;
                if (abort_mem && i == 0) begin
                    push(1'b1, BAD, 1'b1, e);
                    return;
                end
                if (i == mw) begin
                    e.mdr_write     = is_ld;
                    e.instr_retired = is_st;
                end
                push(1'b0, BAD, (i == mw), e);
            end
            if (is_st) return;
        end
        e = '0; e.reg_write = 1'b1; e.mem_to_reg = is_ld; e.instr_retired = 1'b1;
        push(1'b0, BAD, 1'b1, e);
    endtask

    // Drive queued cycles on negedge, compare 1 time unit later.
    task automatic run();
        step_t s;
        outs_t a;
        obs_cycles = 0; obs_ret_at = 0; obs_rets = 0;
        obs_mdr = 0; obs_regw = 0; obs_halt = 0; obs_first_cnt = '0;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            rst = s.rst; opcode = s.op; mem_ready = s.mr;
            #1;
            obs_cycles++;
            a = '{mem_req, mem_we, iord, ir_write, pc_write, mdr_write,
                  aluout_write, reg_write, mem_to_reg, alu_src, alu_op,
                  instr_retired, halted};
            chk("outputs", obs_cycles, 32'(a), 32'(s.exp));
            chk("retire_count", obs_cycles, retire_count, s.cnt);
            if (obs_cycles == 1) obs_first_cnt = retire_count;
            if (instr_retired) begin
                obs_rets++;
                if (obs_ret_at == 0) obs_ret_at = obs_cycles;
            end
            if (mdr_write) obs_mdr++;
            if (reg_write) obs_regw++;
            if (halted && !mem_req) obs_halt++;
        end
    endtask

    initial begin
        rst = 1'b1; opcode = '0; mem_ready = 1'b0; m_cnt = '0;
        @(posedge clk);

        model_reset(2);
        run();
        chk("reset_count", 0, retire_count, 32'd0);

        // addi, zero-wait
        model_instr(I_OP, 0, 0, 0);
        run();
        chk("addi_ret_cycle", 0, obs_ret_at, 4);
        chk("addi_cycles", 0, obs_cycles, 4);

        // R-type with one fetch wait
        model_instr(R_OP, 1, 0, 0);
        run();
        chk("addi_count", 0, obs_first_cnt, 32'd1);
        chk("rtype_ret_cycle", 0, obs_ret_at, 5);

        // lw with two memory wait cycles
        model_instr(LD_OP, 0, 2, 0);
        run();
        chk("lw_first_count", 0, obs_first_cnt, 32'd2);
        chk("lw_ret_cycle", 0, obs_ret_at, 7);
        chk("lw_cycles", 0, obs_cycles, 7);
        chk("lw_mdr_pulses", 0, obs_mdr, 1);

        // sw, zero-wait
        model_instr(ST_OP, 0, 0, 0);
        run();
        chk("sw_first_count", 0, obs_first_cnt, 32'd3);
        chk("sw_ret_cycle", 0, obs_ret_at, 4);
        chk("sw_reg_write", 0, obs_regw, 0);

        // sw aborted by reset in its first MEM cycle, then addi
        model_reset(1);
        model_instr(ST_OP, 0, 0, 1);
        model_instr(I_OP, 0, 0, 0);
        run();
        chk("abort_rets", 0, obs_rets, 1);
        chk("abort_ret_cycle", 0, obs_ret_at, 9);

        // Counter wrap: preload all-ones, retire one add
        model_reset(1);
        run();
        force dut.u_retire.count_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.u_retire.count_q;
        model_instr(R_OP, 0, 0, 0);
        run();
        chk("preload_count", 0, obs_first_cnt, 32'hFFFF_FFFF);

        // Illegal opcode halts; only reset recovers
        model_instr(BAD, 0, 0, 0);
        model_halt(12);
        model_reset(1);
        model_instr(I_OP, 0, 0, 0);
        run();
        chk("wrap_count", 0, obs_first_cnt, 32'd0);
        chk("halt_cycles", 0, obs_halt, 12);
        chk("post_halt_ret_cycle", 0, obs_ret_at, 19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock), then rst (input, 1, synchronous active-high reset).
REQ-002 opcode  input  7  instruction opcode from the instruction register; valid from the DECODE cycle onward.
REQ-003 mem_ready  input  1  memory handshake completion; one cycle of mem_req and mem_ready both high ends the access.
REQ-004 mem_req  output  1  memory access request; held high until mem_ready.
REQ-005 mem_we  output  1  write strobe for the access; valid only while mem_req is high.
REQ-006 iord  output  1  memory address select: 0 selects PC (fetch), 1 selects ALUOut (data).
REQ-007 ir_write, pc_write, mdr_write, aluout_write  output  1 each  single-cycle load enables for the datapath registers.
REQ-008 reg_write, mem_to_reg, alu_src  output  1 each  register-file write, writeback select (1 selects MDR), ALU B-operand select (1 selects immediate).
REQ-009 alu_op  output  2  ALU operation: 00 selects add, 01 selects R-type funct decode.
REQ-010 instr_retired  output  1  one-cycle pulse per completed instruction.
REQ-011 retire_count  output  32  count of retired instructions.
REQ-012 halted  output  1  high while the block is in the HALT state.

Function
REQ-013 The states SHALL be FETCH, DECODE, EXEC, MEM, WB and HALT, held in a state register.
REQ-014 FETCH: mem_req=1, mem_we=0, iord=0; on mem_ready, ir_write=1 and pc_write=1 (PC+4) for that cycle, next state DECODE; otherwise the block stays in FETCH with all enables 0.
REQ-015 DECODE: latch opcode internally, next state per opcode: 0110011, 0010011, 0000011 and 0100011 go to EXEC; any other value goes to HALT.
REQ-016 EXEC: aluout_write=1. R-type: alu_src=0, alu_op=01. I-type, load and store: alu_src=1, alu_op=00. R-type and I-type go to WB; load and store go to MEM.
REQ-017 MEM: mem_req=1, iord=1, mem_we=1 for store and 0 for load; the block stays in MEM until mem_ready.
REQ-018 MEM completion for a load: mdr_write=1, next state WB.
REQ-019 MEM completion for a store: instr_retired=1, next state FETCH.
REQ-020 WB: reg_write=1, mem_to_reg=1 for load and 0 otherwise, instr_retired=1, next state FETCH.
REQ-021 Latency with zero-wait memory: R-type, I-type and store take 4 cycles; load takes 5 cycles; each cycle mem_ready is low adds exactly 1 cycle.
REQ-022 mem_ready SHALL be ignored in DECODE, EXEC, WB and HALT.
REQ-023 HALT: all enables and mem_req are 0, halted=1; HALT is left only by reset.
REQ-024 retire_count SHALL increment by 1 on each instr_retired pulse and wrap from 0xFFFFFFFF to 0.
REQ-025 Every output not asserted by the current state SHALL be 0; outputs are a function of state, the latched opcode and mem_ready only.

Reset
REQ-026 While rst is high, all outputs SHALL be forced to 0 combinationally, including mem_req and mem_we, so that no write occurs in a reset cycle.
REQ-027 At a clk edge with rst high, the state SHALL become FETCH, retire_count and the latched opcode SHALL become 0, and halted SHALL become 0.
REQ-028 Reset asserted mid-access SHALL abort the access; no instr_retired pulse is generated for the aborted instruction.
REQ-029 In the first cycle after rst deasserts, the block SHALL be in FETCH with mem_req=1.

Structure
REQ-030 Package ctrl_pkg SHALL hold the opcode constants (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE), the state enumeration and the ALU_ADD/ALU_RTYPE alu_op encodings.
REQ-031 The 32-bit retire counter SHALL be a separate sub-module, retire_counter (inputs: clk, rst, inc; output: count).

Verification
REQ-032 addi (0010011), mem_ready tied high -> states FETCH, DECODE, EXEC, WB; reg_write=1 in cycle 4; alu_src=1, alu_op=00 in EXEC; retire_count=1.
REQ-033 lw (0000011), mem_ready low for 2 cycles in MEM -> 7 cycles total; mdr_write pulses once; WB has mem_to_reg=1.
REQ-034 sw (0100011), zero-wait -> MEM has mem_we=1 and iord=1; instr_retired in cycle 4; reg_write never asserted.
REQ-035 opcode 1111111 -> HALT after DECODE; halted=1 and mem_req=0 for 10 or more cycles; rst then restores FETCH.
REQ-036 rst asserted in the first MEM cycle of sw -> mem_we=0 in that cycle; retire_count unchanged; FETCH follows.
REQ-037 retire_count preloaded to 0xFFFFFFFF (via force), one add retires -> retire_count=0.
